// File: rtl/fp32_normalize_pack_if.sv
// Handshake bundle for the FP32 normalize/pack stage. The upstream adder side and
// the downstream consumer side share one bundle; the block itself uses the slave view.
interface fp32_normalize_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_overflow;
  logic        out_underflow;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_overflow, out_underflow
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_overflow, out_underflow
  );
endinterface

// File: rtl/fp32_normalize_pack.sv
// Renormalizes the mantissa adder's magnitude, fixes up the exponent and packs an
// IEEE-754 single (truncating, no denormals) through a 2-stage valid/ready pipeline.
module fp32_normalize_pack (
  input  logic                 clk,
  input  logic                 rst_n,
  fp32_normalize_pack_if.slave bus
);

  typedef struct packed {
    logic        ovf;
    logic        unf;
    logic        zero;
    logic [31:0] word;
  } pack_t;

  function automatic logic [4:0] lzc24(input logic [23:0] m);
    logic [4:0] n;
    n = 5'd23;
    for (int i = 0; i < 24; i++) begin
      if (m[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

  // Saturate to infinity or flush to signed zero when the exponent leaves 1..254.
  function automatic pack_t pack_fp32(input logic zero, input logic sign,
                                      input logic signed [9:0] e, input logic [22:0] frac);
    pack_t p;
    p = '0;
    if (zero) begin
      p.zero = 1'b1;
    end else if (e >= 10'sd255) begin
      p.ovf  = 1'b1;
      p.word = {sign, 8'hFF, 23'h0};
    end else if (e <= 10'sd0) begin
      p.unf  = 1'b1;
      p.word = {sign, 31'h0};
    end else begin
      p.word = {sign, e[7:0], frac};
    end
    return p;
  endfunction

  logic                vld_p1, vld_p2;
  logic                adv_p2, ld_p1;
  logic                zero_n, sign_n;
  logic signed [9:0]   exp_in, exp_n;
  logic [4:0]          lz;
  logic [22:0]         frac_n;
  logic                zero_p1, sign_p1;
  logic signed [9:0]   exp_p1;
  logic [22:0]         frac_p1;
  pack_t               pk_p1;
  pack_t               out_p2;

  assign adv_p2      = !vld_p2 || bus.out_ready;
  assign ld_p1       = !vld_p1 || adv_p2;
  assign bus.in_ready = ld_p1;

  assign exp_in = $signed({2'b00, bus.in_exp});
  assign lz     = lzc24(bus.in_mant[23:0]);

  always_comb begin
    zero_n = (bus.in_mant == 25'd0);
    sign_n = bus.in_sign && !zero_n;
    exp_n  = exp_in;
    frac_n = '0;
    if (bus.in_mant[24]) begin
      frac_n = bus.in_mant[23:1];
      exp_n  = exp_in + 10'sd1;
    end else begin
      // Shifting the low 23 bits drops the leading one out of the top, leaving the fraction.
      frac_n = bus.in_mant[22:0] << lz;
      exp_n  = exp_in - $signed({5'b00000, lz});
    end
  end

  // Stage 1: normalize
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else if (ld_p1) vld_p1 <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (ld_p1 && bus.in_valid) begin
      zero_p1 <= zero_n;
      sign_p1 <= sign_n;
      exp_p1  <= exp_n;
      frac_p1 <= frac_n;
    end
  end

  assign pk_p1 = pack_fp32(zero_p1, sign_p1, exp_p1, frac_p1);

  // Stage 2: pack into output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      out_p2 <= '0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) out_p2 <= pk_p1;
    end
  end

  assign bus.out_valid     = vld_p2;
  assign bus.out_result    = out_p2.word;
  assign bus.out_zero      = out_p2.zero;
  assign bus.out_overflow  = out_p2.ovf;
  assign bus.out_underflow = out_p2.unf;

endmodule

// File: tb/tb_fp32_normalize_pack.sv
// Scoreboard bench for fp32_normalize_pack: directed vectors, backpressure, mid-stream
// reset and a randomized stream with random downstream stalls.
module tb_fp32_normalize_pack;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fp32_normalize_pack_if bus();

  fp32_normalize_pack dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  int n_acc   = 0;
  logic [34:0] exp_q[$];
  bit          stall_prev = 0;
  logic [34:0] held;
  bit          tog_run;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Reference: {ovf, unf, zero, word}
  function automatic logic [34:0] model(input logic s, input logic [7:0] ex, input logic [24:0] m);
    int e;
    logic [24:0] mm;
    if (m == 25'd0) return {3'b001, 32'h0};
    e = int'(ex);
    mm = m;
    if (mm[24]) begin
      mm = mm >> 1;
      e = e + 1;
    end else begin
      while (!mm[23]) begin
        mm = mm << 1;
        e = e - 1;
      end
    end
    if (e >= 255) return {3'b100, s, 8'hFF, 23'h0};
    if (e <= 0)   return {3'b010, s, 31'h0};
    return {3'b000, s, 8'(e), mm[22:0]};
  endfunction

  function automatic logic [34:0] cur_out();
    return {bus.out_overflow, bus.out_underflow, bus.out_zero, bus.out_result};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) chk("hold", 64'(cur_out()), 64'(held));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra", 64'(1), 64'(0));
        end else begin
          logic [34:0] e;
          e = exp_q.pop_front();
          chk("res", 64'(bus.out_result), 64'(e[31:0]));
          chk("flg", 64'({bus.out_overflow, bus.out_underflow, bus.out_zero}), 64'(e[34:32]));
        end
        n_out++;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held = cur_out();
    end
  end

  task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m, input logic [34:0] want);
    bit acc;
    int n;
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_mant  = m;
    acc = 0;
    n = 0;
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      n++;
      if (!acc && n > 300) begin
        chk("acc_timeout", 64'(0), 64'(1));
        #1 bus.in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(want);
    n_acc++;
    #1 bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = 8'd0;
    bus.in_mant   = 25'd0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_vld", 64'(bus.out_valid), 64'(0));
    chk("rst_out", 64'(cur_out()), 64'(0));
    chk("rst_rdy", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic with latency check
    send(1'b0, 8'd127, 25'h0800000, {3'b000, 32'h3F800000});
    @(negedge clk); chk("lat1", 64'(bus.out_valid), 64'(0));
    @(negedge clk); chk("lat2", 64'(bus.out_valid), 64'(1));
    @(posedge clk); #1;

    send(1'b0, 8'd127, 25'h1000000, {3'b000, 32'h40000000});
    send(1'b1, 8'd127, 25'h1C00000, {3'b000, 32'hC0600000});
    send(1'b0, 8'd150, 25'h0000001, {3'b000, 32'h3F800000});
    send(1'b1, 8'd150, 25'h0000000, {3'b001, 32'h00000000});
    send(1'b1, 8'd254, 25'h1800000, {3'b100, 32'hFF800000});
    send(1'b1, 8'd1,   25'h0400000, {3'b010, 32'h80000000});
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: 4 items, downstream stalled 5 cycles
    bus.out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        send(1'b0, 8'd100, 25'h0812345, model(1'b0, 8'd100, 25'h0812345));
        send(1'b1, 8'd10,  25'h1ABCDEF, model(1'b1, 8'd10,  25'h1ABCDEF));
        send(1'b0, 8'd200, 25'h0000F00, model(1'b0, 8'd200, 25'h0000F00));
        send(1'b1, 8'd5,   25'h0001000, model(1'b1, 8'd5,   25'h0001000));
      end
    join_none
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("bp_acc", 64'(n_acc), 64'(2));
    chk("bp_rdy", 64'(bus.in_ready), 64'(0));
    @(posedge clk); #1 bus.out_ready = 1'b1;
    begin
      int base;
      base = n_out;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk); #2;
        chk("bp_rate", 64'(n_out - base), 64'(k));
      end
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset with two items in flight
    bus.out_ready = 1'b0;
    send(1'b0, 8'd130, 25'h0A00000, model(1'b0, 8'd130, 25'h0A00000));
    send(1'b1, 8'd120, 25'h1200000, model(1'b1, 8'd120, 25'h1200000));
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_vld", 64'(bus.out_valid), 64'(0));
    chk("mrst_out", 64'(cur_out()), 64'(0));
    chk("mrst_rdy", 64'(bus.in_ready), 64'(1));
    exp_q.delete();
    begin
      int base;
      base = n_out;
      @(posedge clk); #1 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("mrst_none", 64'(n_out - base), 64'(0));
    end

    // Random stream with random downstream stalls
    tog_run = 1;
    fork
      while (tog_run) begin
        @(posedge clk); #1;
        if (tog_run) bus.out_ready = 1'($urandom_range(0, 1));
      end
    join_none
    for (int i = 0; i < 40; i++) begin
      logic s;
      logic [7:0] e;
      logic [24:0] m;
      s = 1'($urandom_range(0, 1));
      e = 8'($urandom_range(0, 255));
      m = 25'($urandom) >> $urandom_range(0, 25);
      send(s, e, m, model(s, e, m));
    end
    tog_run = 0;
    @(posedge clk); #2 bus.out_ready = 1'b1;
    begin
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
        @(posedge clk);
        t++;
      end
    end
    #1;
    chk("drain", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp32_normalize_pack.md
# fp32_normalize_pack

Normalization and packing stage that sits directly downstream of the signed-magnitude mantissa adder in the FP32 matrix-multiplier datapath. It accepts the adder's 25-bit magnitude result, its sign, and the common (aligned) exponent. It renormalizes the magnitude (carry right-shift or leading-zero left-shift), adjusts the exponent, handles zero, overflow and underflow, and emits a packed IEEE-754 single-precision word. The block is a 2-stage pipeline with valid/ready handshakes on both sides.

## Interface
Parameters:
- none (fixed FP32: 8-bit exponent, bias 127, 23-bit fraction)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream presents a result
- in_ready  out  1  block accepts this cycle (transfer = in_valid & in_ready)
- in_sign  in  1  result sign from adder
- in_exp  in  8  biased exponent shared by the aligned operands
- in_mant  in  25  magnitude from adder; bit 23 = hidden-one position, bit 24 = carry
- out_valid  out  1  out_result/flags valid
- out_ready  in  1  downstream accepts (transfer = out_valid & out_ready)
- out_result  out  32  packed {sign, exp[7:0], frac[22:0]}
- out_zero  out  1  exact-zero result
- out_overflow  out  1  result saturated to infinity
- out_underflow  out  1  result flushed to zero

## Operation
- Internal exponent: 10-bit signed, e = {2'b00, in_exp}.
- Stage 1 (normalize), registered:
  - in_mant == 0: zero case; sign forced to 0.
  - in_mant[24] == 1: m = in_mant[24:1] (bit 0 truncated); e = e + 1.
  - otherwise: lz = leading zeros of in_mant[23:0] (0..23); m = in_mant[23:0] << lz; e = e − lz.
- Stage 2 (pack), registered to outputs:
  - zero: result 0x00000000, out_zero=1.
  - e >= 255: result {sign, 8'hFF, 23'h0}, out_overflow=1.
  - e <= 0: result {sign, 31'h0} (signed zero, no denormals), out_underflow=1.
  - else: result {sign, e[7:0], m[22:0]}.
  - At most one flag is set per result.
- Rounding: truncation only. Round-to-nearest is not implemented.
- Pipeline control:
  - Each stage holds a valid bit.
  - A stage loads when it is empty or when its contents move forward in the same cycle.
  - in_ready = !s1_valid | (!s2_valid | out_ready).
  - Stage 2 holds its output stable while out_valid & !out_ready.
- No item is dropped or duplicated. Order is preserved. Full throughput is 1 result per cycle.

## Timing
- Latency: 2 cycles from the accepting edge to out_valid, when not stalled.
- Reset (asynchronous assert):
  - out_valid=0, all stage valids=0.
  - out_result=0, out_zero=0, out_overflow=0, out_underflow=0.
  - in_ready=1 after reset.
- Reset asserted mid-stream: all in-flight items are discarded and none emerge after release. Release is synchronous to clk in the system; the block needs no internal synchronizer.
- Full condition (both stages valid, out_ready=0):
  - in_ready=0.
  - Upstream must hold its inputs; held data is not sampled.
- Simultaneous drain and fill (out_ready=1 while full): stage 2 takes stage 1, stage 1 takes the new input in the same cycle, and in_ready stays 1.
- While out_valid & !out_ready, out_result and flags must not change.
- out_* change only on clk edges. in_ready is combinational from out_ready and internal state only.

## Test plan
- Basic: sign=0, exp=127, mant=0x0800000 -> out_result=0x3F800000, no flags, out_valid exactly 2 cycles after acceptance.
- Carry: sign=0, exp=127, mant=0x1000000 -> 0x40000000. Also sign=1, exp=127, mant=0x1C00000 -> 0xC0600000.
- Cancellation: exp=150, mant=0x0000001 -> 0x3F800000. Then mant=0, sign=1 -> 0x00000000 with out_zero=1.
- Overflow/underflow:
  - exp=254, mant=0x1800000, sign=1 -> 0xFF800000, out_overflow=1.
  - exp=1, mant=0x0400000, sign=1 -> 0x80000000, out_underflow=1.
- Backpressure: stream 4 items back-to-back with out_ready=0 for 5 cycles.
  - in_ready drops after 2 accepts.
  - Outputs stay stable.
  - On release, all 4 appear in order, 1 per cycle, with no loss or duplicates.
- Reset mid-stream: assert rst_n=0 with 2 items in flight -> out_valid=0 and out_result=0 immediately; no stale item appears after release.
